i2c_rx_fifo: RTL and testbench

I2C_RX_FIFO -- requirements
Module: i2c_rx_fifo

---
 rtl/i2c_rx_fifo.sv | 93 +++++++++
 tb/tb_i2c_rx_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_rx_fifo.sv
// Receive-side byte FIFO for the I2C slave path.
// First-word-fall-through read port with sticky overrun/underrun flags.
module i2c_rx_fifo #(
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     RX_write_enable_slave,
    input  logic [7:0]               rx_data_slave,
    input  logic                     read_enable,
    input  logic                     flush,
    input  logic                     clear_errors,
    output logic [7:0]               read_data,
    output logic                     RX_fifo_empty,
    output logic                     RX_fifo_full,
    output logic                     RX_fifo_almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     underrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_ok;
    logic          wr_ok;
    logic          ov_evt;
    logic          un_evt;

    assign RX_fifo_empty       = (count == '0);
    assign RX_fifo_full        = (count == CW'(DEPTH));
    assign RX_fifo_almost_full = (count >= CW'(AF_LEVEL));

    // A pop on a full FIFO frees the slot the same-cycle write lands in.
    assign rd_ok  = read_enable && !RX_fifo_empty && !flush;
    assign wr_ok  = RX_write_enable_slave && !flush && (!RX_fifo_full || rd_ok);
    assign ov_evt = RX_write_enable_slave && !flush && RX_fifo_full && !rd_ok;
    assign un_evt = read_enable && !flush && RX_fifo_empty;

    assign read_data = RX_fifo_empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= rx_data_slave;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A fresh error event outranks a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (ov_evt) begin
                overrun <= 1'b1;
            end else if (clear_errors) begin
                overrun <= 1'b0;
            end
            if (un_evt) begin
                underrun <= 1'b1;
            end else if (clear_errors) begin
                underrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2c_rx_fifo.sv
// Directed bench for i2c_rx_fifo (DEPTH=8, AF_LEVEL=7).
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_i2c_rx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we  = 1'b0;
    logic [7:0] din = 8'h00;
    logic       re  = 1'b0;
    logic       fl  = 1'b0;
    logic       ce  = 1'b0;
    logic [7:0] read_data;
    logic       empty;
    logic       full;
    logic       afull;
    logic [3:0] count;
    logic       overrun;
    logic       underrun;

    int n_cmp = 0;
    int n_bad = 0;

    i2c_rx_fifo #(.DEPTH(8), .AF_LEVEL(7)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .RX_write_enable_slave (we),
        .rx_data_slave         (din),
        .read_enable           (re),
        .flush                 (fl),
        .clear_errors          (ce),
        .read_data             (read_data),
        .RX_fifo_empty         (empty),
        .RX_fifo_full          (full),
        .RX_fifo_almost_full   (afull),
        .count                 (count),
        .overrun               (overrun),
        .underrun              (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r,
                         input logic f, input logic c);
        we  = w;
        din = d;
        re  = r;
        fl  = f;
        ce  = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [7:0] d);
        drive(1'b1, d, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #1;
        chk(tag, {24'h0, read_data}, {24'h0, exp});
        tick();
    endtask

    initial begin
        // reset state while rst is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", {31'h0, empty}, 32'd1);
        chk("rst_full", {31'h0, full}, 32'd0);
        chk("rst_afull", {31'h0, afull}, 32'd0);
        chk("rst_count", {28'h0, count}, 32'd0);
        chk("rst_rdata", {24'h0, read_data}, 32'h00);
        chk("rst_flags", {30'h0, overrun, underrun}, 32'd0);
        rst = 1'b0;

        // single byte in and out
        push(8'hA5);
        chk("a5_count", {28'h0, count}, 32'd1);
        chk("a5_empty", {31'h0, empty}, 32'd0);
        chk("a5_rdata", {24'h0, read_data}, 32'hA5);
        pop_chk("a5_pop", 8'hA5);
        chk("a5_empty2", {31'h0, empty}, 32'd1);
        chk("a5_rdata2", {24'h0, read_data}, 32'h00);

        // fill to full, then overrun
        for (int i = 0; i < 8; i++) begin
            push(8'(i));
            chk($sformatf("fill_cnt%0d", i), {28'h0, count}, 32'(i + 1));
            chk($sformatf("fill_af%0d", i), {31'h0, afull}, (i >= 6) ? 32'd1 : 32'd0);
            chk($sformatf("fill_full%0d", i), {31'h0, full}, (i == 7) ? 32'd1 : 32'd0);
        end
        push(8'hFF);
        chk("ovr_flag", {31'h0, overrun}, 32'd1);
        chk("ovr_count", {28'h0, count}, 32'd8);
        for (int i = 0; i < 8; i++) begin
            pop_chk($sformatf("drain%0d", i), 8'(i));
        end
        chk("drain_empty", {31'h0, empty}, 32'd1);
        chk("drain_ovr_sticky", {31'h0, overrun}, 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        chk("ovr_clear", {31'h0, overrun}, 32'd0);

        // full FIFO, read and write together
        for (int i = 0; i < 8; i++) begin
            push(8'h10 + 8'(i));
        end
        drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        #1;
        chk("frw_rdata", {24'h0, read_data}, 32'h10);
        tick();
        chk("frw_count", {28'h0, count}, 32'd8);
        chk("frw_ovr", {31'h0, overrun}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            pop_chk($sformatf("frw_pop%0d", i), 8'h10 + 8'(i));
        end
        pop_chk("frw_pop_55", 8'h55);
        chk("frw_empty", {31'h0, empty}, 32'd1);

        // empty FIFO, read and write together
        drive(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        tick();
        chk("erw_under", {31'h0, underrun}, 32'd1);
        chk("erw_count", {28'h0, count}, 32'd1);
        chk("erw_rdata", {24'h0, read_data}, 32'h3C);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        chk("erw_clear", {31'h0, underrun}, 32'd0);

        // mid-level read and write together
        drive(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
        tick();
        chk("mrw_count", {28'h0, count}, 32'd1);
        chk("mrw_rdata", {24'h0, read_data}, 32'h44);
        pop_chk("mrw_pop", 8'h44);

        // new error wins over clear_errors
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        tick();
        chk("clr_race", {31'h0, underrun}, 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        chk("clr_after", {31'h0, underrun}, 32'd0);

        // flush beats a same-cycle write
        for (int i = 0; i < 5; i++) begin
            push(8'h60 + 8'(i));
        end
        chk("fl_pre", {28'h0, count}, 32'd5);
        drive(1'b1, 8'h11, 1'b1, 1'b1, 1'b0);
        tick();
        chk("fl_count", {28'h0, count}, 32'd0);
        chk("fl_empty", {31'h0, empty}, 32'd1);
        chk("fl_flags", {30'h0, overrun, underrun}, 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        chk("fl_keeps_flag", {31'h0, underrun}, 32'd1);

        // asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) begin
            push(8'h21 + 8'(i));
        end
        chk("mr_pre", {28'h0, count}, 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_count", {28'h0, count}, 32'd0);
        chk("mr_empty", {31'h0, empty}, 32'd1);
        chk("mr_rdata", {24'h0, read_data}, 32'h00);
        chk("mr_flags", {30'h0, overrun, underrun}, 32'd0);
        drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        tick();
        chk("mr_strobe_ign", {28'h0, count}, 32'd0);
        rst = 1'b0;
        push(8'h99);
        chk("mr_wr_count", {28'h0, count}, 32'd1);
        chk("mr_wr_rdata", {24'h0, read_data}, 32'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
